// File: rtl/fetch_unit.sv
// Purpose: instruction fetch unit; one outstanding imem read feeding a small decode buffer.
// Latency: dec_valid rises the cycle after imem_ack; redirect flushes the buffer next cycle.
// Backpressure: dec_ready low holds the buffer; issue stalls when full (depth 2 with FETCH_SKID_BUF_EN, else 1).
module fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
);

`ifdef FETCH_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t              state;
    state_t              state_nx;
    logic                started;
    logic [ADDR_W-1:0]   pc;
    logic [1:0]          count;
    // Two physical slots; with DEPTH=1 slot 1 is never written and folds away.
    logic [INSTR_W-1:0]  buf_instr [2];
    logic [ADDR_W-1:0]   buf_pc    [2];

    logic                pop;
    logic                push;
    logic                can_issue;
    logic                wr_idx;

    assign dec_valid = (count != 2'd0);
    assign dec_instr = buf_instr[0];
    assign dec_pc    = buf_pc[0];
    assign imem_addr = pc;

    assign pop       = dec_valid & dec_ready;
    // Only a live WAIT accepts data; a redirect in the same cycle discards it.
    assign push      = (state == WAIT) & imem_ack & ~redirect_valid;
    assign can_issue = (count < 2'(DEPTH)) | pop;
    // Slot index after an optional same-cycle pop.
    assign wr_idx    = pop ? (count == 2'd2) : (count == 2'd1);

    // Hold off the first request until one clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) started <= 1'b0;
        else     started <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and request generation; redirect wins over everything.
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && started && can_issue) begin
                    imem_req = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) state_nx = imem_ack ? IDLE : DROP;
                else if (imem_ack)  state_nx = IDLE;
            end
            DROP: begin
                // The outstanding read is stale; swallow its ack.
                if (imem_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Program counter: redirect target, else advance past each accepted word (wraps).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (push)           pc <= pc + ADDR_W'(4);
    end

    // Decode buffer: slot 0 is oldest; pop shifts down, push lands after the survivors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
            if (pop) begin
                buf_instr[0] <= buf_instr[1];
                buf_pc[0]    <= buf_pc[1];
            end
            if (push) begin
                buf_instr[wr_idx] <= imem_rdata;
                buf_pc[wr_idx]    <= pc;
            end
        end
    end

endmodule
